// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller: steers one digit per slot onto the
// MC14495 decoder inputs, with leading dead-time and frame-synchronous commit.
module disp_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] hexs,
  input  logic [3:0]  points,
  input  logic [3:0]  les,
  output logic [3:0]  D,
  output logic        point,
  output logic        LE,
  output logic [3:0]  AN,
  output logic        pend,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_hex_q, disp_hex_d, pend_hex_q, pend_hex_d;
  logic [3:0]    disp_pt_q, disp_pt_d, pend_pt_q, pend_pt_d;
  logic [3:0]    disp_le_q, disp_le_d, pend_le_q, pend_le_d;
  logic          pend_q, pend_d;
  logic [3:0]    d_q, d_d, an_q, an_d;
  logic          point_q, point_d, le_q, le_d, fd_q, fd_d;
  logic          slot_end, frame_end, blank_d;

  assign slot_end  = (cnt_q == CNT_MAX);
  assign frame_end = slot_end && (idx_q == 2'd3);
  assign cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
  assign idx_d     = slot_end ? idx_q + 2'd1 : idx_q;

  // Outputs are computed from next-state values so they line up with cnt/idx.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign blank_d = 1'b0;
    end else begin : g_blank
      assign blank_d = (cnt_d < CW'(BLANK_CYC));
    end
  endgenerate

  always_comb begin
    disp_hex_d = disp_hex_q;
    disp_pt_d  = disp_pt_q;
    disp_le_d  = disp_le_q;
    pend_hex_d = pend_hex_q;
    pend_pt_d  = pend_pt_q;
    pend_le_d  = pend_le_q;
    pend_d     = pend_q;
    if (frame_end && pend_q) begin
      disp_hex_d = pend_hex_q;
      disp_pt_d  = pend_pt_q;
      disp_le_d  = pend_le_q;
      pend_d     = 1'b0;
    end
    // A load on the commit edge refills pending after the old data commits.
    if (load) begin
      pend_hex_d = hexs;
      pend_pt_d  = points;
      pend_le_d  = les;
      pend_d     = 1'b1;
    end
    fd_d    = frame_end;
    d_d     = disp_hex_d[{idx_d, 2'b00} +: 4];
    point_d = disp_pt_d[idx_d];
    if (blank_d) begin
      an_d = 4'b1111;
      le_d = 1'b1;
    end else begin
      an_d = ~(4'b0001 << idx_d);
      le_d = disp_le_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      disp_hex_q <= '0;
      disp_pt_q  <= '0;
      disp_le_q  <= '0;
      pend_hex_q <= '0;
      pend_pt_q  <= '0;
      pend_le_q  <= '0;
      pend_q     <= 1'b0;
      d_q        <= 4'd0;
      point_q    <= 1'b0;
      le_q       <= 1'b1;
      an_q       <= 4'b1111;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_hex_q <= disp_hex_d;
      disp_pt_q  <= disp_pt_d;
      disp_le_q  <= disp_le_d;
      pend_hex_q <= pend_hex_d;
      pend_pt_q  <= pend_pt_d;
      pend_le_q  <= pend_le_d;
      pend_q     <= pend_d;
      d_q        <= d_d;
      point_q    <= point_d;
      le_q       <= le_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign D          = d_q;
  assign point      = point_q;
  assign LE         = le_q;
  assign AN         = an_q;
  assign pend       = pend_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized bench for disp_scan_ctrl: two instances (8/2 and 2/0 timing) share
// stimulus and are compared each cycle against a time-index reference model.
module tb_disp_scan_ctrl;

  localparam int SD0 = 8, BC0 = 2;
  localparam int SD1 = 2, BC1 = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] hexs = '0;
  logic [3:0]  points = '0, les = '0;

  logic [3:0] d0, an0, d1, an1;
  logic       pt0, le0, pd0, fd0, pt1, le1, pd1, fd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.SCAN_DIV(SD0), .BLANK_CYC(BC0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .hexs(hexs), .points(points), .les(les),
    .D(d0), .point(pt0), .LE(le0), .AN(an0), .pend(pd0), .frame_done(fd0));

  disp_scan_ctrl #(.SCAN_DIV(SD1), .BLANK_CYC(BC1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .hexs(hexs), .points(points), .les(les),
    .D(d1), .point(pt1), .LE(le1), .AN(an1), .pend(pd1), .frame_done(fd1));

  // Model: t = cycles since reset; cnt and idx follow from t by division.
  typedef struct packed {
    logic [31:0] t;
    logic        rst;
    logic [15:0] dh, ph;
    logic [3:0]  dp, dl, pp, pl;
    logic        pend;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t m_reset();
    mdl_t m;
    m = '0;
    m.rst = 1'b1;
    return m;
  endfunction

  function automatic mdl_t m_step(mdl_t m, int sd, logic ld, logic [15:0] h,
                                  logic [3:0] p, logic [3:0] l);
    int t;
    t = int'(m.t);
    if ((t % (4 * sd)) == 4 * sd - 1 && m.pend) begin
      m.dh = m.ph; m.dp = m.pp; m.dl = m.pl; m.pend = 1'b0;
    end
    if (ld) begin
      m.ph = h; m.pp = p; m.pl = l; m.pend = 1'b1;
    end
    m.t   = m.t + 32'd1;
    m.rst = 1'b0;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_out(input string pfx, input mdl_t m, input int sd, input int bc,
                           input logic [3:0] an, input logic [3:0] d, input logic pt,
                           input logic le, input logic pd, input logic fd);
    int t, cnt, idx;
    logic [3:0] e_an, e_d;
    logic e_pt, e_le, e_fd;
    t   = int'(m.t);
    cnt = t % sd;
    idx = (t / sd) % 4;
    if (m.rst) begin
      e_an = 4'b1111; e_d = 4'd0; e_pt = 1'b0; e_le = 1'b1; e_fd = 1'b0;
    end else begin
      e_d  = 4'((m.dh >> (4 * idx)) & 16'hF);
      e_pt = m.dp[idx];
      e_fd = (t > 0) && (t % (4 * sd) == 0);
      if (cnt < bc) begin
        e_an = 4'b1111; e_le = 1'b1;
      end else begin
        e_an = 4'b1111; e_an[idx] = 1'b0; e_le = m.dl[idx];
      end
    end
    chk({pfx, "_AN"}, 32'(an), 32'(e_an));
    chk({pfx, "_D"}, 32'(d), 32'(e_d));
    chk({pfx, "_point"}, 32'(pt), 32'(e_pt));
    chk({pfx, "_LE"}, 32'(le), 32'(e_le));
    chk({pfx, "_pend"}, 32'(pd), 32'(m.pend));
    chk({pfx, "_frame_done"}, 32'(fd), 32'(e_fd));
    chk({pfx, "_an_onehot"}, 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic check_all();
    check_out("d0", m0, SD0, BC0, an0, d0, pt0, le0, pd0, fd0);
    check_out("d1", m1, SD1, BC1, an1, d1, pt1, le1, pd1, fd1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m0 = m_reset(); m1 = m_reset();
    end else begin
      m0 = m_step(m0, SD0, load, hexs, points, les);
      m1 = m_step(m1, SD1, load, hexs, points, les);
    end
    #1;
    check_all();
    // Non-load data wiggles to show it has no effect without a load.
    load   = 1'b0;
    hexs   = 16'($urandom);
    points = 4'($urandom);
    les    = 4'($urandom);
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
    load = 1'b1; hexs = h; points = p; les = l;
    $display("load hexs=%h points=%b les=%b t0=%0d", h, p, l, m0.t);
    tick();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the next edge of dut0 is a frame end.
  task automatic to_frame_end();
    for (int i = 0; i < 4 * SD0 + 1; i++) begin
      if (int'(m0.t) % (4 * SD0) == 4 * SD0 - 1) break;
      tick();
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    m0 = m_reset(); m1 = m_reset();
    #1 check_all();
    tick();
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    m0 = m_reset(); m1 = m_reset();
    do_reset();
    run(5);
    do_load(16'h1234, 4'b0100, 4'b0000);
    run(100);
    do_load(16'h9876, 4'b0000, 4'b1000);
    run(70);
    to_frame_end();
    run(2);
    do_load(16'hAAAA, 4'b1111, 4'b0000);
    run(2);
    do_load(16'h5555, 4'b0000, 4'b0000);
    run(70);
    to_frame_end();
    run(4);
    do_load(16'h1111, 4'b0001, 4'b0010);
    to_frame_end();
    do_load(16'h2222, 4'b0010, 4'b0100);
    run(70);
    run(13);
    do_reset();
    run(20);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0)
        do_load(16'($urandom), 4'($urandom), 4'($urandom));
      else
        tick();
      if (i == 1500) do_reset();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
